// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction classes and field helpers for the 5-stage MIPS-like core.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Undefined opcode, used to fill squashed or idle fetch slots.
  localparam logic [31:0] NOP_IR = 32'h7c00_0000;

  typedef enum logic [2:0] {NOP, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} itype_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
  } fields_t;

  function automatic fields_t split_ir(input logic [31:0] ir);
    fields_t f;
    f.op  = ir[31:26];
    f.rs  = ir[25:21];
    f.rt  = ir[20:16];
    f.rd  = ir[15:11];
    f.imm = {{16{ir[15]}}, ir[15:0]};
    return f;
  endfunction

  function automatic itype_t decode_type(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

  function automatic alu_op_t alu_sel(input logic [5:0] op);
    case (op)
      OP_SUB, OP_SUBI: return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_SLT, OP_SLTI: return ALU_SLT;
      OP_MUL:          return ALU_MUL;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu32.sv
// 32-bit integer ALU: add/sub/and/or/signed-compare/low-half multiply.
module alu32
  import mips32_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
      ALU_MUL: y = a * b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/pipelined_processor.sv
// In-order IF/ID/EX/MEM/WB core with unified memory, full ALU forwarding,
// EX-stage branch resolution and a sticky halt.
module pipelined_processor
  import mips32_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int XLEN      = 32
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] npc;
  } if_id_t;

  typedef struct packed {
    itype_t          t;
    alu_op_t         op;
    logic            is_beqz;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dest;
    logic            wen;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] npc;
  } id_ex_t;

  typedef struct packed {
    itype_t          t;
    logic            wen;
    logic [4:0]      dest;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sdata;
  } ex_mem_t;

  typedef struct packed {
    itype_t          t;
    logic            wen;
    logic [4:0]      dest;
    logic [XLEN-1:0] res;
  } mem_wb_t;

  logic [XLEN-1:0] Reg [0:31];
  logic [XLEN-1:0] Mem [0:MEM_WORDS-1];
  logic [XLEN-1:0] PC;
  logic            HALTED;
  logic            fetch_stop;

  if_id_t  if_id;
  id_ex_t  id_ex, id_dec;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;
  fields_t f;

  logic [XLEN-1:0] rf_a, rf_b, fa, fb, alu_b, alu_y, target, ld_data;
  logic            taken, hlt_in_id;

  assign f = split_ir(if_id.ir);

  // Register read with write-through from the instruction currently in WB.
  always_comb begin
    rf_a = Reg[f.rs];
    if (f.rs == 5'd0) rf_a = '0;
    else if (mem_wb.wen && mem_wb.dest == f.rs) rf_a = mem_wb.res;
    rf_b = Reg[f.rt];
    if (f.rt == 5'd0) rf_b = '0;
    else if (mem_wb.wen && mem_wb.dest == f.rt) rf_b = mem_wb.res;
  end

  always_comb begin
    id_dec         = '0;
    id_dec.t       = decode_type(f.op);
    id_dec.op      = alu_sel(f.op);
    id_dec.is_beqz = (f.op == OP_BEQZ);
    id_dec.rs      = f.rs;
    id_dec.rt      = f.rt;
    id_dec.dest    = (id_dec.t == RR_ALU) ? f.rd : f.rt;
    id_dec.wen     = (id_dec.t inside {RR_ALU, RM_ALU, LOAD}) && (id_dec.dest != 5'd0);
    id_dec.a       = rf_a;
    id_dec.b       = rf_b;
    id_dec.imm     = f.imm;
    id_dec.npc     = if_id.npc;
  end

  assign hlt_in_id = (id_dec.t == HALT);

  // Youngest producer wins; a load still in MEM is not forwarded (load-use slot).
  always_comb begin
    fa = id_ex.a;
    if (mem_wb.wen && mem_wb.dest == id_ex.rs) fa = mem_wb.res;
    if (ex_mem.wen && ex_mem.t != LOAD && ex_mem.dest == id_ex.rs) fa = ex_mem.alu;
    fb = id_ex.b;
    if (mem_wb.wen && mem_wb.dest == id_ex.rt) fb = mem_wb.res;
    if (ex_mem.wen && ex_mem.t != LOAD && ex_mem.dest == id_ex.rt) fb = ex_mem.alu;
  end

  assign alu_b  = (id_ex.t == RR_ALU) ? fb : id_ex.imm;
  assign taken  = (id_ex.t == BRANCH) && (id_ex.is_beqz ? (fa == '0) : (fa != '0));
  assign target = id_ex.npc + id_ex.imm;

  alu32 u_alu (
    .op (id_ex.op),
    .a  (fa),
    .b  (alu_b),
    .y  (alu_y)
  );

  assign ld_data = Mem[ex_mem.alu[AW-1:0]];
  assign halted  = HALTED;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      PC         <= '0;
      HALTED     <= 1'b0;
      fetch_stop <= 1'b0;
      if_id      <= '{ir: NOP_IR, npc: '0};
      id_ex      <= '0;
      ex_mem     <= '0;
      mem_wb     <= '0;
    end else if (!HALTED) begin
      if (mem_wb.t == HALT) HALTED <= 1'b1;

      if (taken) begin
        PC    <= target;
        if_id <= '{ir: NOP_IR, npc: '0};
      end else if (fetch_stop || hlt_in_id) begin
        if_id <= '{ir: NOP_IR, npc: '0};
      end else begin
        if_id <= '{ir: Mem[PC[AW-1:0]], npc: PC + XLEN'(1)};
        PC    <= PC + XLEN'(1);
      end

      // A taken branch squashes an HLT sitting in ID, so fetch keeps going.
      if (!taken && hlt_in_id) fetch_stop <= 1'b1;

      id_ex  <= taken ? '0 : id_dec;
      ex_mem <= '{t: id_ex.t, wen: id_ex.wen, dest: id_ex.dest, alu: alu_y, sdata: fb};
      mem_wb <= '{t: ex_mem.t, wen: ex_mem.wen, dest: ex_mem.dest,
                  res: (ex_mem.t == LOAD) ? ld_data : ex_mem.alu};
    end
  end

  // Architectural arrays are not reset; latches are NOP during reset so nothing lands here.
  always_ff @(posedge clk1) begin
    if (!HALTED) begin
      if (mem_wb.wen) Reg[mem_wb.dest] <= mem_wb.res;
      if (ex_mem.t == STORE) Mem[ex_mem.alu[AW-1:0]] <= ex_mem.sdata;
    end
  end

endmodule

// File: tb/tb_pipelined_processor.sv
// Directed programs plus random straight/forward-branch programs checked against an ISA-level model.
module tb_pipelined_processor;

  localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_AND = 6'b000010,
                         T_OR = 6'b000011, T_SLT = 6'b000100, T_MUL = 6'b000101,
                         T_LW = 6'b001000, T_SW = 6'b001001, T_ADDI = 6'b001010,
                         T_SUBI = 6'b001011, T_SLTI = 6'b001100, T_BNEQZ = 6'b001101,
                         T_BEQZ = 6'b001110, T_HLT = 6'b111111, T_JUNK = 6'b010110;

  logic clk1 = 1'b0;
  logic rst_n = 1'b1;
  logic halted;

  pipelined_processor #(.MEM_WORDS(1024), .XLEN(32)) dut (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .halted (halted)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mreg [0:31];
  logic [31:0] mmem [0:1023];
  logic [31:0] prog [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] hlt();
    return {T_HLT, 26'd0};
  endfunction

  function automatic logic [31:0] filler();
    return rr(T_OR, 15, 7, 7);
  endfunction

  task automatic begin_test();
    @(negedge clk1);
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin dut.Reg[i] = '0; mreg[i] = '0; end
    for (int i = 0; i < 1024; i++) begin dut.Mem[i] = '0; mmem[i] = '0; end
    prog.delete();
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    dut.Reg[i] = v;
    mreg[i] = v;
  endtask

  task automatic set_mem(input int a, input logic [31:0] v);
    dut.Mem[a] = v;
    mmem[a] = v;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) set_mem(i, prog[i]);
  endtask

  task automatic model_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) mreg[r] = v;
  endtask

  // Sequential ISA interpreter; also predicts the halt cycle: one cycle per
  // executed instruction, two bubbles per taken branch, four to drain.
  task automatic model_run(output int exp_cyc, output logic [31:0] exp_pc);
    logic [31:0] pc, ir, a, b, imm, ea;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    int d, t;
    logic tk;
    pc = '0; d = 0; t = 0; exp_cyc = -1; exp_pc = '0;
    for (int s = 0; s < 20000; s++) begin
      ir  = mmem[pc[9:0]];
      op  = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      imm = {{16{ir[15]}}, ir[15:0]};
      a = mreg[rs]; b = mreg[rt]; ea = a + imm;
      if (op == T_HLT) begin
        exp_cyc = d + 2 * t + 5;
        exp_pc  = pc + 1;
        return;
      end
      tk = 1'b0;
      case (op)
        T_ADD:   model_wr(rd, a + b);
        T_SUB:   model_wr(rd, a - b);
        T_AND:   model_wr(rd, a & b);
        T_OR:    model_wr(rd, a | b);
        T_SLT:   model_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        T_MUL:   model_wr(rd, a * b);
        T_ADDI:  model_wr(rt, a + imm);
        T_SUBI:  model_wr(rt, a - imm);
        T_SLTI:  model_wr(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
        T_LW:    model_wr(rt, mmem[ea[9:0]]);
        T_SW:    mmem[ea[9:0]] = b;
        T_BNEQZ: tk = (a != 0);
        T_BEQZ:  tk = (a == 0);
        default: ;
      endcase
      d++;
      if (tk) begin t++; pc = pc + 1 + imm; end
      else pc = pc + 1;
    end
  endtask

  task automatic reset_checks(input string tag);
    repeat (2) @(negedge clk1);
    check({tag, " rst halted"}, {31'd0, halted}, 32'd0);
    check({tag, " rst pc"}, dut.PC, 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int exp_cyc, input logic [31:0] exp_pc);
    int cyc;
    cyc = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk1); #1;
      if (halted) begin cyc = c; break; end
    end
    check({tag, " halt cycle"}, cyc, exp_cyc);
    repeat (4) @(posedge clk1);
    #1;
    check({tag, " halted"}, {31'd0, halted}, 32'd1);
    check({tag, " frozen pc"}, dut.PC, exp_pc);
  endtask

  task automatic cmp_model(input string tag, input int lo, input int hi);
    for (int i = 0; i < 32; i++) check($sformatf("%s R%0d", tag, i), dut.Reg[i], mreg[i]);
    for (int a = lo; a <= hi; a++) check($sformatf("%s M%0d", tag, a), dut.Mem[a], mmem[a]);
  endtask

  task automatic run_prog(input string tag, input int lo, input int hi);
    int ec;
    logic [31:0] ep;
    load_prog();
    model_run(ec, ep);
    reset_checks(tag);
    release_rst();
    wait_halt(tag, ec, ep);
    cmp_model(tag, lo, hi);
  endtask

  task automatic build_t1(input bit with_fill);
    prog.push_back(ri(T_ADDI, 1, 0, 10));
    prog.push_back(ri(T_ADDI, 2, 0, 20));
    prog.push_back(ri(T_ADDI, 3, 0, 25));
    if (with_fill) begin prog.push_back(filler()); prog.push_back(filler()); end
    prog.push_back(rr(T_ADD, 4, 1, 2));
    if (with_fill) prog.push_back(filler());
    prog.push_back(rr(T_ADD, 5, 4, 3));
    prog.push_back(hlt());
  endtask

  task automatic t1_values(input string tag);
    check({tag, " R1"}, dut.Reg[1], 32'd10);
    check({tag, " R2"}, dut.Reg[2], 32'd20);
    check({tag, " R3"}, dut.Reg[3], 32'd25);
    check({tag, " R4"}, dut.Reg[4], 32'd30);
    check({tag, " R5"}, dut.Reg[5], 32'd55);
  endtask

  task automatic gen_random(input int n);
    int k, x, y, z;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 12);
      x = $urandom_range(0, 7); y = $urandom_range(0, 7); z = $urandom_range(0, 7);
      case (k)
        0: prog.push_back(rr(T_ADD, x, y, z));
        1: prog.push_back(rr(T_SUB, x, y, z));
        2: prog.push_back(rr(T_AND, x, y, z));
        3: prog.push_back(rr(T_OR,  x, y, z));
        4: prog.push_back(rr(T_SLT, x, y, z));
        5: prog.push_back(rr(T_MUL, x, y, z));
        6: prog.push_back(ri(T_ADDI, x, y, $urandom_range(0, 65535)));
        7: prog.push_back(ri(T_SUBI, x, y, $urandom_range(0, 65535)));
        8: prog.push_back(ri(T_SLTI, x, y, $urandom_range(0, 65535)));
        9: prog.push_back(ri(T_SW, x, 0, 300 + $urandom_range(0, 63)));
        10: begin
          prog.push_back(ri(T_LW, x, 0, 300 + $urandom_range(0, 63)));
          prog.push_back(filler());
        end
        11: prog.push_back(ri($urandom_range(0, 1) ? T_BEQZ : T_BNEQZ, 0, y, $urandom_range(0, 2)));
        default: prog.push_back({T_JUNK, 26'($urandom)});
      endcase
    end
    repeat (3) prog.push_back(filler());
    prog.push_back(hlt());
  endtask

  initial begin
    // 1: filled dependency chain
    begin_test();
    build_t1(1'b1);
    run_prog("t1", 0, -1);
    t1_values("t1");

    // 2: same chain relying on forwarding
    begin_test();
    build_t1(1'b0);
    run_prog("t2", 0, -1);
    t1_values("t2");

    // 3: load, forwarded add, store
    begin_test();
    set_mem(120, 32'd85);
    prog.push_back(ri(T_ADDI, 1, 0, 120));
    prog.push_back(ri(T_LW, 2, 1, 0));
    prog.push_back(filler());
    prog.push_back(ri(T_ADDI, 2, 2, 45));
    prog.push_back(ri(T_SW, 2, 1, 1));
    prog.push_back(hlt());
    run_prog("t3", 118, 123);
    check("t3 Mem121", dut.Mem[121], 32'd130);

    // 4: factorial loop, HLT squashed by taken branch each iteration
    begin_test();
    set_reg(10, 32'd200);
    set_mem(200, 32'd7);
    prog.push_back(ri(T_ADDI, 2, 0, 1));
    prog.push_back(ri(T_LW, 3, 10, 0));
    prog.push_back(filler());
    prog.push_back(rr(T_MUL, 2, 2, 3));
    prog.push_back(ri(T_SUBI, 3, 3, 1));
    prog.push_back(ri(T_BNEQZ, 0, 3, -3));
    prog.push_back(hlt());
    run_prog("t4", 200, 200);
    check("t4 R2", dut.Reg[2], 32'd5040);
    check("t4 R3", dut.Reg[3], 32'd0);

    // 5: R0 stays zero
    begin_test();
    set_reg(1, 32'd7);
    prog.push_back(ri(T_ADDI, 0, 0, 5));
    prog.push_back(rr(T_ADD, 1, 0, 0));
    prog.push_back(hlt());
    run_prog("t5", 0, -1);
    check("t5 R0", dut.Reg[0], 32'd0);
    check("t5 R1", dut.Reg[1], 32'd0);

    // 6: reset while ADDI R3 is in WB, then rerun
    begin_test();
    build_t1(1'b1);
    load_prog();
    begin
      int ec;
      logic [31:0] ep;
      model_run(ec, ep);
      reset_checks("t6");
      release_rst();
      repeat (6) @(posedge clk1);
      #2 rst_n = 1'b0;
      #1;
      check("t6 abort pc", dut.PC, 32'd0);
      check("t6 abort halted", {31'd0, halted}, 32'd0);
      repeat (3) @(negedge clk1);
      check("t6 abort R1", dut.Reg[1], 32'd10);
      check("t6 abort R2", dut.Reg[2], 32'd20);
      check("t6 abort R3", dut.Reg[3], 32'd0);
      check("t6 abort R4", dut.Reg[4], 32'd0);
      check("t6 abort R5", dut.Reg[5], 32'd0);
      rst_n = 1'b1;
      wait_halt("t6", ec, ep);
      cmp_model("t6", 0, -1);
      t1_values("t6");
    end

    // random programs
    for (int p = 0; p < 8; p++) begin
      begin_test();
      for (int r = 1; r < 8; r++) set_reg(r, ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom);
      for (int a = 300; a < 364; a++) set_mem(a, $urandom);
      gen_random($urandom_range(12, 24));
      run_prog($sformatf("rnd%0d", p), 300, 363);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
